// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the iterative carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cla_state_e;

  function automatic int cla_ngroups(input int width, input int group);
    return width / group;
  endfunction

  // True when the WIDTH/GROUP pair can be built: GROUP in 1..8 and dividing WIDTH.
  function automatic bit cla_params_ok(input int width, input int group);
    return (group >= 1) && (group <= 8) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: every internal carry is a flat sum of
// products of g/p terms and the group carry-in, so there is no ripple path.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cg_i,
  output logic [GROUP-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o,
  output logic             p_o,
  output logic             g_o
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cg, one product term per j.
  always_comb begin
    logic carry;
    logic run;
    c     = '0;
    c[0]  = cg_i;
    g_o   = 1'b0;
    carry = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      carry = g[i];
      run   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry = carry | (run & g[j]);
        run   = run & p[j];
      end
      if (i == GROUP - 1) begin
        g_o = carry;
      end
      c[i+1] = carry | (run & cg_i);
    end
  end

  assign s_o     = p ^ c[GROUP-1:0];
  assign cout_o  = c[GROUP];
  assign c_msb_o = c[GROUP-1];
  assign p_o     = &p;

endmodule

// File: rtl/cla_adder_iter.sv
// Multi-cycle adder: resolves one GROUP-bit slice per cycle through a single
// lookahead group, chaining the group carry through a register.
module cla_adder_iter
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  localparam int NGROUPS = cla_ngroups(WIDTH, GROUP);
  localparam int IDXW    = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  if (!cla_params_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("cla_adder_iter: GROUP must be 1..8 and divide WIDTH");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, ready never depends on valid.

  cla_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [GROUP-1:0] a_slice;
  logic [GROUP-1:0] b_slice;
  logic [GROUP-1:0] grp_s;
  logic             grp_cout;
  logic             grp_c_msb;
  logic             grp_p;
  logic             grp_g;
  logic             last_grp;

  assign last_grp = (idx_q == IDXW'(NGROUPS - 1));

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int gi = 0; gi < NGROUPS; gi++) begin
      if (idx_q == IDXW'(gi)) begin
        a_slice = a_q[gi*GROUP +: GROUP];
        b_slice = b_q[gi*GROUP +: GROUP];
      end
    end
  end

  cla_group #(.GROUP(GROUP)) u_group (
    .a_i     (a_slice),
    .b_i     (b_slice),
    .cg_i    (carry_q),
    .s_o     (grp_s),
    .cout_o  (grp_cout),
    .c_msb_o (grp_c_msb),
    .p_o     (grp_p),
    .g_o     (grp_g)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_grp) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      BUSY: begin
        for (int gi = 0; gi < NGROUPS; gi++) begin
          if (idx_q == IDXW'(gi)) sum_d[gi*GROUP +: GROUP] = grp_s;
        end
        // Chained carry from the group generate/propagate pair.
        carry_d = grp_g | (grp_p & carry_q);
        idx_d   = last_grp ? '0 : idx_q + IDXW'(1);
        if (last_grp) begin
          cout_d = grp_g | (grp_p & carry_q);
          ovf_d  = grp_cout ^ grp_c_msb;
        end
      end
      default: ;
    endcase
  end

  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cla_adder_iter.sv
// Bench for cla_adder_iter: four instances (GROUP 1,2,4,8), one active at a time,
// checked every cycle against a plain-arithmetic model of the handshake and sum.
module tb_cla_adder_iter;
  import cla_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid_v;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        cin_i;
  logic        out_ready;
  wire  [3:0]  in_ready_v;
  wire  [3:0]  out_valid_v;
  wire  [3:0]  cout_v;
  wire  [3:0]  ovf_v;
  wire  [15:0] sum_v [4];
  wire  [1:0]  dbg_v [4];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cur   = 2;
  bit b2b   = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    cla_adder_iter #(.WIDTH(16), .GROUP(1 << k)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_v[k]),
      .in_ready    (in_ready_v[k]),
      .a           (a_i),
      .b           (b_i),
      .cin         (cin_i),
      .out_valid   (out_valid_v[k]),
      .out_ready   (out_ready),
      .sum         (sum_v[k]),
      .cout        (cout_v[k]),
      .ovf         (ovf_v[k]),
      .dbg_state_o (dbg_v[k])
    );
  end

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, group %0d)", nm, act, exp, cyc, 1 << cur);
    end
  endtask

  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v    = (x[15] == y[15]) && (full[15] != x[15]);
    return {full[16], v, full[15:0]};
  endfunction

  // Scoreboard: one outstanding transaction at most.
  logic [17:0] exp_q[$];
  bit          pending   = 0;
  bit          have_prev = 0;
  bit          rst_seen  = 0;
  bit          ev;
  int          acc_cyc   = 0;
  int          prev_acc  = 0;
  int          ngr;

  always @(negedge clk) begin
    ngr = 16 >> cur;
    ev  = pending && ((cyc - acc_cyc) >= ngr);
    if (cyc >= 1) begin
      if (rst_seen) begin
        chk("rst_sum", 32'(sum_v[cur]), 32'd0);
        chk("rst_cout", 32'(cout_v[cur]), 32'd0);
        chk("rst_ovf", 32'(ovf_v[cur]), 32'd0);
      end
      chk("out_valid", 32'(out_valid_v[cur]), 32'(ev));
      chk("in_ready", 32'(in_ready_v[cur]), 32'(!pending));
      if (!pending) chk("dbg_idle", 32'(dbg_v[cur]), 32'(IDLE));
      if (ev && exp_q.size() > 0) begin
        chk("sum", 32'(sum_v[cur]), 32'(exp_q[0][15:0]));
        chk("cout", 32'(cout_v[cur]), 32'(exp_q[0][17]));
        chk("ovf", 32'(ovf_v[cur]), 32'(exp_q[0][16]));
      end
    end
    rst_seen = rst;
    if (rst) begin
      pending   = 0;
      have_prev = 0;
      exp_q.delete();
    end else if (in_valid_v[cur] && !pending) begin
      if (b2b && have_prev) chk("accept_spacing", 32'(cyc + 1 - prev_acc), 32'(ngr + 2));
      prev_acc  = cyc + 1;
      have_prev = 1;
      pending   = 1;
      acc_cyc   = cyc + 1;
      exp_q.push_back(ref_add(a_i, b_i, cin_i));
    end else if (ev && out_ready) begin
      pending = 0;
      void'(exp_q.pop_front());
    end
  end

  // Driver: called and returns just after a rising edge.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       input int hold, input logic [15:0] es, input logic eco, input logic eov);
    int t;
    a_i = ta;
    b_i = tb;
    cin_i = tc;
    in_valid_v[cur] = 1'b1;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready_v[cur] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready_v[cur]);
    end
    @(posedge clk); #1;
    in_valid_v[cur] = 1'b0;
    a_i = 16'($urandom_range(0, 65535));
    b_i = 16'($urandom_range(0, 65535));
    cin_i = 1'($urandom_range(0, 1));
    t = 0;
    while (!out_valid_v[cur] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      tests++; fails++;
      $display("FAIL result_timeout: out_valid stayed %0b, required 1", out_valid_v[cur]);
    end
    chk("lit_sum", 32'(sum_v[cur]), 32'(es));
    chk("lit_cout", 32'(cout_v[cur]), 32'(eco));
    chk("lit_ovf", 32'(ovf_v[cur]), 32'(eov));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_ack", 32'(in_ready_v[cur]), 32'd1);
  endtask

  task automatic pin_model(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                           input logic [15:0] es, input logic eco, input logic eov);
    chk("model_pin", 32'(ref_add(ta, tb, tc)), 32'({eco, eov, es}));
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [17:0] r;
    logic [15:0] ta, tb;
    logic        tc;
    rst = 1'b1;
    in_valid_v = '0;
    out_ready = 1'b1;
    a_i = '0;
    b_i = '0;
    cin_i = 1'b0;
    cur = 2;
    reset_dut(3);
    chk("post_reset_in_ready", 32'(in_ready_v[cur]), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid_v[cur]), 32'd0);

    pin_model(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    pin_model(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    pin_model(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);
    pin_model(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b1, 0, 16'h1001, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 5, 16'h5555, 1'b0, 1'b0);

    // Reset during the second BUSY cycle discards the operation.
    a_i = 16'hFFFF;
    b_i = 16'hFFFF;
    cin_i = 1'b1;
    in_valid_v[cur] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[cur] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_in_ready", 32'(in_ready_v[cur]), 32'd1);
    chk("midop_out_valid", 32'(out_valid_v[cur]), 32'd0);
    chk("midop_sum", 32'(sum_v[cur]), 32'd0);
    chk("midop_cout", 32'(cout_v[cur]), 32'd0);
    do_op(16'h0F0F, 16'h00F1, 1'b1, 0, 16'h1001, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      rst = 1'b1;
      cur = k;
      reset_dut(2);
      b2b = 1;
      for (int i = 0; i < 1000; i++) begin
        ta = 16'($urandom_range(0, 65535));
        tb = 16'($urandom_range(0, 65535));
        tc = 1'($urandom_range(0, 1));
        r  = ref_add(ta, tb, tc);
        do_op(ta, tb, tc, 0, r[15:0], r[17], r[16]);
      end
      b2b = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
